tdm_demux4: RTL and testbench

TDM_DEMUX4 -- requirements
Module: tdm_demux4

---
 rtl/tdm_demux4_pkg.sv | 32 +++
 rtl/tdm_demux4.sv | 159 +++++++++++++++
 tb/tb_tdm_demux4.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux4_pkg.sv
// Shared TDM framing definitions used by the demux receiver and the matching
// mux-side transmitter: channel count, counter widths, FSM state encoding and
// the per-sample control decision record.
package tdm_demux4_pkg;

  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned CNT_W       = $clog2(NUM_CH);
  localparam int unsigned ERR_CNT_W   = 8;
  localparam int unsigned LAST_CH     = NUM_CH - 1;

  // Framing state: HUNT waits for a frame_sync, LOCK follows the channel order.
  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } tdm_state_e;

  // Per-sample actions decided by the next-state logic.
  typedef struct packed {
    logic shadow_wr;   // write din into shadow[wr_idx]
    logic publish;     // copy shadows + din to the output bank
    logic sync_err;    // framing violation on this sample
  } tdm_ctl_t;

  // Saturating increment for the error counter.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    logic [ERR_CNT_W-1:0] r;
    if (v == {ERR_CNT_W{1'b1}}) r = v;
    else                        r = v + ERR_CNT_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/tdm_demux4.sv
// tdm_demux4 -- 4:1 time-division demultiplexer with frame-sync tracking.
// Samples arrive on din (qualified by din_valid) in channel order 0..3, with
// frame_sync marking channel 0. Samples are staged in a shadow bank and the
// complete frame is published to ch0..ch3 on the edge that captures channel 3.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   din              time-multiplexed sample
//   din_valid        din carries a sample this cycle
//   frame_sync       qualified by din_valid, marks channel 0
//   ch0..ch3         last complete frame (registered)
//   frame_valid      one-cycle strobe, new frame published
//   sync_err         one-cycle strobe, framing violation
//   locked           high while in LOCK (registered)
//   err_cnt          saturating count of sync_err events
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  input  logic                 frame_sync,
  output logic [WIDTH-1:0]     ch0,
  output logic [WIDTH-1:0]     ch1,
  output logic [WIDTH-1:0]     ch2,
  output logic [WIDTH-1:0]     ch3,
  output logic                 frame_valid,
  output logic                 sync_err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  tdm_state_e           r_state;
  tdm_state_e           w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [CNT_W-1:0]     w_wr_idx;
  tdm_ctl_t             w_ctl;

  logic [WIDTH-1:0]     r_shadow [NUM_CH];
  logic [WIDTH-1:0]     r_ch     [NUM_CH];
  logic                 r_frame_valid;
  logic                 r_sync_err;
  logic                 r_locked;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HUNT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and per-sample action decode; nothing moves without din_valid.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_idx    = '0;
    w_ctl       = '0;

    if (din_valid) begin
      unique case (r_state)
        ST_HUNT: begin
          // Non-sync samples are dropped silently while hunting.
          if (frame_sync) begin
            w_ctl.shadow_wr = 1'b1;
            w_wr_idx        = '0;
            w_cnt_nxt       = CNT_W'(1);
            w_state_nxt     = ST_LOCK;
          end
        end

        ST_LOCK: begin
          if (frame_sync) begin
            // Sync restarts the frame; it is an error only if mid-frame.
            w_ctl.sync_err  = (r_cnt != '0);
            w_ctl.shadow_wr = 1'b1;
            w_wr_idx        = '0;
            w_cnt_nxt       = CNT_W'(1);
          end else if (r_cnt == '0) begin
            // Channel-0 slot without sync: framing lost.
            w_ctl.sync_err  = 1'b1;
            w_state_nxt     = ST_HUNT;
          end else begin
            w_ctl.shadow_wr = 1'b1;
            w_wr_idx        = r_cnt;
            w_cnt_nxt       = r_cnt + CNT_W'(1);
            w_ctl.publish   = (r_cnt == CNT_W'(LAST_CH));
          end
        end

        default: begin
          w_state_nxt = ST_HUNT;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Shadow bank: stages the frame being assembled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        r_shadow[i] <= '0;
      end
    end else if (w_ctl.shadow_wr) begin
      r_shadow[w_wr_idx] <= din;
    end
  end

  // Output bank: updated only when the channel-3 sample completes a frame.
  // Channel 3 comes straight from din since its shadow write is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        r_ch[i] <= '0;
      end
    end else if (w_ctl.publish) begin
      for (int i = 0; i < int'(LAST_CH); i++) begin
        r_ch[i] <= r_shadow[i];
      end
      r_ch[LAST_CH] <= din;
    end
  end

  // Status strobes, lock flag and error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      r_locked      <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_frame_valid <= w_ctl.publish;
      r_sync_err    <= w_ctl.sync_err;
      r_locked      <= (w_state_nxt == ST_LOCK);
      if (w_ctl.sync_err) begin
        r_err_cnt <= sat_inc(r_err_cnt);
      end
    end
  end

  assign ch0         = r_ch[0];
  assign ch1         = r_ch[1];
  assign ch2         = r_ch[2];
  assign ch3         = r_ch[3];
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;
  assign locked      = r_locked;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed framing scenarios followed by
// randomized traffic, compared against a queue-based frame model.
module tb_tdm_demux4;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] ch0, ch1, ch2, ch3;
  logic             frame_valid;
  logic             sync_err;
  logic             locked;
  logic [7:0]       err_cnt;

  int n_total;
  int n_bad;

  // Reference model: framing expressed as a queue of samples in the current frame.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_ch [4];
  logic             m_locked;
  logic             m_fv;
  logic             m_err;
  int               m_errcnt;

  tdm_demux4 #(.WIDTH(WIDTH)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .ch0         (ch0),
    .ch1         (ch1),
    .ch2         (ch2),
    .ch3         (ch3),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked),
    .err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 4; i++) m_ch[i] = '0;
    m_locked = 1'b0;
    m_fv     = 1'b0;
    m_err    = 1'b0;
    m_errcnt = 0;
  endtask

  task automatic model_edge(input logic v, input logic s, input logic [WIDTH-1:0] d);
    m_fv  = 1'b0;
    m_err = 1'b0;
    if (v) begin
      if (s) begin
        if (m_locked && m_q.size() != 0) m_err = 1'b1;
        m_q.delete();
        m_q.push_back(d);
        m_locked = 1'b1;
      end else if (m_locked) begin
        if (m_q.size() == 0) begin
          m_err    = 1'b1;
          m_locked = 1'b0;
        end else begin
          m_q.push_back(d);
          if (m_q.size() == 4) begin
            for (int i = 0; i < 4; i++) m_ch[i] = m_q[i];
            m_fv = 1'b1;
            m_q.delete();
          end
        end
      end
    end
    if (m_err && m_errcnt < 255) m_errcnt++;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ch0"},    32'(ch0),         32'(m_ch[0]));
    chk({tag, ".ch1"},    32'(ch1),         32'(m_ch[1]));
    chk({tag, ".ch2"},    32'(ch2),         32'(m_ch[2]));
    chk({tag, ".ch3"},    32'(ch3),         32'(m_ch[3]));
    chk({tag, ".fv"},     32'(frame_valid), 32'(m_fv));
    chk({tag, ".err"},    32'(sync_err),    32'(m_err));
    chk({tag, ".locked"}, 32'(locked),      32'(m_locked));
    chk({tag, ".errcnt"}, 32'(err_cnt),     32'(m_errcnt));
  endtask

  task automatic step(input string tag, input logic v, input logic s, input logic [WIDTH-1:0] d);
    @(negedge clk);
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    model_edge(v, s, d);
    #1;
    check_all(tag);
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".hold"});
    @(negedge clk);
    rst_n      = 1'b1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic send_frame(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
    step(tag, 1'b1, 1'b1, a);
    step(tag, 1'b1, 1'b0, b);
    step(tag, 1'b1, 1'b0, c);
    step(tag, 1'b1, 1'b0, d);
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame.
    send_frame("f1", 8'hA1, 8'hB2, 8'hC3, 8'hD4);
    chk("f1.fv_direct", 32'(frame_valid), 32'd1);
    step("f1.after", 1'b0, 1'b0, 8'h00);
    chk("f1.fv_drop", 32'(frame_valid), 32'd0);

    // Frame with idle gaps; stray sync on idle cycles must be ignored.
    step("gap", 1'b1, 1'b1, 8'h5A);
    step("gap", 1'b1, 1'b0, 8'h6B);
    step("gap", 1'b0, 1'b1, 8'hEE);
    step("gap", 1'b0, 1'b0, 8'hEE);
    step("gap", 1'b0, 1'b1, 8'hEE);
    step("gap", 1'b1, 1'b0, 8'h7C);
    step("gap", 1'b1, 1'b0, 8'h8D);

    // Early sync.
    step("early", 1'b1, 1'b1, 8'h11);
    step("early", 1'b1, 1'b0, 8'h22);
    send_frame("early", 8'h33, 8'h44, 8'h55, 8'h66);
    chk("early.errcnt", 32'(err_cnt), 32'd1);

    // Missing sync then ignored sample while hunting.
    step("miss", 1'b1, 1'b0, 8'h77);
    chk("miss.locked", 32'(locked), 32'd1 - 32'(sync_err));
    step("miss", 1'b1, 1'b0, 8'h88);

    // Reset mid-frame, then a fresh frame.
    step("rstmid", 1'b1, 1'b1, 8'h01);
    step("rstmid", 1'b1, 1'b0, 8'h02);
    do_reset("rstmid");
    step("rstmid", 1'b1, 1'b0, 8'h03);
    send_frame("rstmid", 8'h91, 8'h92, 8'h93, 8'h94);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      send_frame("sat", 8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3));
      step("sat", 1'b1, 1'b0, 8'hF0);
    end
    chk("sat.final", 32'(err_cnt), 32'd255);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      logic v;
      logic s;
      v = ($urandom_range(0, 99) < 75);
      if (!m_locked || m_q.size() == 0) s = ($urandom_range(0, 99) < 85);
      else                              s = ($urandom_range(0, 99) < 6);
      step("rnd", v, s, 8'($urandom));
      if ($urandom_range(0, 999) == 0) do_reset("rnd.rst");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
